// File: rtl/basic_memory_if.sv
// rtl/basic_memory_if.sv - request/response bundle for basic_memory
interface basic_memory_if #(
    parameter int xlen = 32
);
    logic            r_v;
    logic            w_v;
    logic [xlen-1:0] adr;
    logic [xlen-1:0] data;
    logic [3:0]      strobe;
    logic [xlen-1:0] resp;
    logic            ack;

    modport master (
        output r_v, w_v, adr, data, strobe,
        input  resp, ack
    );

    modport slave (
        input  r_v, w_v, adr, data, strobe,
        output resp, ack
    );
endinterface

// File: rtl/basic_memory.sv
// rtl/basic_memory.sv - single-port 32-bit word RAM, byte-lane strobes, registered read/ack
module basic_memory #(
    parameter int xlen  = 32,
    parameter int DEPTH = 4096,
    parameter int ADR_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    basic_memory_if.slave bus
);
    logic [xlen-1:0] mem [0:DEPTH-1];

    logic [xlen-1:0] r_resp;
    logic            r_ack;
    logic [ADR_W-1:0] w_idx;
    logic            w_unused_adr;

    assign w_idx        = bus.adr[ADR_W+1:2];
    assign w_unused_adr = ^{bus.adr[xlen-1:ADR_W+2], bus.adr[1:0]};

    // rst_n is active-high; requests in a reset cycle are dropped, contents kept.
    always_ff @(posedge clk) begin
        if (!rst_n && bus.w_v) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.strobe[i]) begin
                    mem[w_idx][8*i +: 8] <= bus.data[8*i +: 8];
                end
            end
        end
    end

    // Read samples the pre-write word, giving read-before-write on collisions.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_resp <= '0;
            r_ack  <= 1'b0;
        end else begin
            if (bus.r_v) begin
                r_resp <= mem[w_idx];
            end
            r_ack <= bus.r_v | bus.w_v;
        end
    end

    assign bus.resp = r_resp;
    assign bus.ack  = r_ack;
endmodule

// File: tb/tb_basic_memory.sv
// tb/tb_basic_memory.sv - scoreboard bench for basic_memory against a word-array model
module tb_basic_memory;
    typedef struct {
        logic        ack;
        logic [31:0] resp;
    } exp_t;

    logic clk;
    logic rst_n;

    basic_memory_if #(.xlen(32)) bus ();

    basic_memory #(.xlen(32), .DEPTH(4096)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] model_mem [0:4095];
    logic [31:0] model_resp;
    exp_t        exp_q [$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_err = 0;

    // One call per clock edge: drive the request, predict the response it earns.
    task automatic step(input bit rst, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int   idx;
        exp_t e;
        rst_n      = rst;
        bus.r_v    = r;
        bus.w_v    = w;
        bus.adr    = a;
        bus.data   = d;
        bus.strobe = s;
        idx = int'((a / 32'd4) % 32'd4096);
        if (rst) begin
            model_resp = 32'h0;
            e.ack      = 1'b0;
        end else begin
            if (r) model_resp = model_mem[idx];
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (s[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
                end
            end
            e.ack = r | w;
        end
        e.resp = model_resp;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                n_vec++;
                if (bus.ack !== mon_e.ack || bus.resp !== mon_e.resp) begin
                    n_err++;
                    $display("FAIL resp_ack @%0t: got ack=%0b resp=%08h, required ack=%0b resp=%08h",
                             $time, bus.ack, bus.resp, mon_e.ack, mon_e.resp);
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          op;
        int          idx;

        step(1, 1, 1, 32'h0, 32'hFFFF_FFFF, 4'hF);
        step(1, 1, 1, 32'h0, 32'hFFFF_FFFF, 4'hF);

        for (int k = 0; k < 16; k++) begin
            case (k)
                0:       d = 32'h0000_0013;
                4:       d = 32'h1122_3344;
                8:       d = 32'h0000_0000;
                default: d = $urandom();
            endcase
            step(0, 0, 1, 32'(k * 4), d, 4'hF);
        end

        // Reset with a live write pending: write must be discarded.
        step(1, 1, 1, 32'h0, 32'hBAD0_BAD0, 4'hF);
        step(1, 1, 1, 32'h0, 32'hBAD0_BAD0, 4'hF);
        step(0, 1, 0, 32'h0, 32'h0, 4'h0);

        step(0, 0, 1, 32'h12, 32'hAABB_CCDD, 4'b0101);
        step(0, 1, 0, 32'h10, 32'h0, 4'h0);
        step(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        step(0, 1, 0, 32'h10, 32'h0, 4'h0);

        step(0, 1, 1, 32'h20, 32'h5A5A_5A5A, 4'hF);
        step(0, 1, 0, 32'h20, 32'h0, 4'h0);

        step(0, 0, 1, 32'h4000, 32'hCAFE_F00D, 4'hF);
        step(0, 1, 0, 32'h0, 32'h0, 4'h0);

        step(0, 1, 0, 32'h0, 32'h0, 4'h0);
        step(0, 1, 0, 32'h4, 32'h0, 4'h0);
        step(0, 1, 0, 32'h8, 32'h0, 4'h0);
        step(0, 0, 0, 32'h8, 32'h0, 4'h0);
        step(0, 0, 0, 32'h3C, 32'h0, 4'h0);

        step(0, 0, 1, 32'h4, 32'h9999_9999, 4'h0);
        step(0, 1, 0, 32'h4, 32'h0, 4'h0);

        for (int k = 0; k < 400; k++) begin
            op  = $urandom_range(0, 19);
            idx = $urandom_range(0, 15);
            a   = ($urandom() & 32'hFFFF_C000) | 32'(idx * 4) | 32'($urandom_range(0, 3));
            d   = $urandom();
            if (op == 0)
                step(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, d, 4'($urandom()));
            else if (op < 4)
                step(0, 0, 0, a, d, 4'($urandom()));
            else if (op < 10)
                step(0, 1, 0, a, d, 4'($urandom()));
            else if (op < 15)
                step(0, 0, 1, a, d, 4'($urandom()));
            else
                step(0, 1, 1, a, d, 4'($urandom()));
        end
        step(0, 0, 0, 32'h0, 32'h0, 4'h0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/basic_memory.md
# basic_memory

Single-port, word-organised 32-bit synchronous RAM with byte-lane write strobes and a one-cycle registered read/acknowledge. Two instances serve the `cpu` core: an instruction memory with reads permanently enabled and writes tied off, and a data memory driven by the core's load/store port. Contents are preloaded in simulation by `$readmemh` into the internal array `mem`, so that array name and layout are part of the interface.

## Interface
- `xlen`, default 32: data/address width; only 32 is supported.
- `DEPTH`, default 4096: number of `xlen`-bit words; must be a power of two.
- `ADR_W`, default `$clog2(DEPTH)`: word-index width (derived).
- Internal array `mem`: `logic [xlen-1:0] mem [0:DEPTH-1]`, index = word address. It is hierarchically visible for `$readmemh`. One hex word per line loads at index 0 upward.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: synchronous, active-high reset. It is asserted when 1, despite the name, and sampled on the rising edge of `clk`.
- `r_v` in 1: read request valid.
- `w_v` in 1: write request valid.
- `adr` in `xlen`: byte address.
- `data` in `xlen`: write data, little-endian byte lanes.
- `strobe` in 4: byte-lane write enables; bit i selects `data[8i+7:8i]`.
- `resp` out `xlen`: read data.
- `ack` out 1: request completed.

## Operation
- Word index = `adr[ADR_W+1:2]`.
  - `adr[1:0]` is ignored: accesses are always word-aligned.
  - Upper address bits are ignored, so addresses wrap modulo `4*DEPTH` bytes.
- **Read** (`r_v`=1 at an edge): `resp` loads `mem[idx]`. The full word is returned regardless of `strobe`; the core extracts sub-words.
- **Write** (`w_v`=1 at an edge): for each i with `strobe[i]`=1, `mem[idx][8i+7:8i]` gets `data[8i+7:8i]`. Other lanes are unchanged. `w_v`=1 with `strobe`=0 writes nothing but still acknowledges.
- **Simultaneous `r_v` and `w_v`**, same or different address: the write is performed, and `resp` returns the pre-write contents of `mem[idx]` (read-before-write).
- **`ack`**: the registered value of `r_v | w_v`.
- **Idle** (`r_v`=`w_v`=0): `resp` holds its last value; `ack` becomes 0.
- No back-pressure. A new request is accepted every cycle, and each request is acknowledged exactly once, one cycle later.
- **Reset** (`rst_n`=1 at an edge):
  - `resp` becomes 0 and `ack` becomes 0.
  - Any request presented in that cycle is discarded; no write occurs.
  - `mem` contents are NOT cleared, so preloaded images survive reset.
- There is no state machine beyond the two output registers.

## Timing
- Read latency: 1 cycle. A request sampled at edge N produces valid `resp` and `ack`=1 after edge N, for the whole of cycle N+1.
- A write is visible to a read sampled at edge N+1 or later.
- Back-to-back reads at edges N, N+1, N+2 return data in cycles N+1, N+2, N+3, with `ack` held high.
- Reset takes effect at the first edge with `rst_n`=1. Outputs are 0 from then until one cycle after the first request following deassertion.
- Reset asserted mid-stream: the acknowledgement due at that edge is suppressed (`ack`=0, `resp`=0).
- No combinational path from any input to any output.

## Test plan
- **Reset:** hold `rst_n`=1 for 2 cycles with `r_v`=1 and `adr`=0 → `resp`=0, `ack`=0. Release → next cycle `resp`=`mem[0]` (preloaded 0x00000013), `ack`=1.
- **Full write then read:** write `adr`=0x10, `data`=0xDEADBEEF, `strobe`=0xF; next cycle read 0x10 → `resp`=0xDEADBEEF, `ack`=1 in both response cycles.
- **Byte strobes:** `mem[4]`=0x11223344. Write `adr`=0x12 (low bits ignored), `data`=0xAABBCCDD, `strobe`=0b0101 → read `adr`=0x10 returns 0x11BB33DD.
- **Read-before-write:** `mem[8]`=0x0. Same cycle `r_v`=`w_v`=1, `adr`=0x20, `data`=0x5A5A5A5A, `strobe`=0xF → `resp`=0x0. Following read returns 0x5A5A5A5A.
- **Wrap-around:** with `DEPTH`=4096, write 0xCAFEF00D at `adr`=0x4000 → read at 0x0 returns 0xCAFEF00D.
- **Idle and pipelined reads:** reads at 0x0, 0x4, 0x8 on consecutive cycles, then idle → `resp` sequence `mem[0]`, `mem[1]`, `mem[2]` with `ack` 1,1,1. Then `ack`=0 while `resp` holds `mem[2]`.
